ysyx_22040931_lsu_ctrl: RTL

Multi-cycle load/store sequencer between the decoder's memory controls (mem_ena, mem_wr, memrop, memwop) and a valid/ready data-memory bus.
- Latches one access and stalls the core while the access is in flight.
- For stores, builds byte-lane write data and mask.
- For loads, extracts and sign- or zero-extends the result.
- Flags misaligned accesses and bus timeouts.

---
 rtl/ysyx_22040931_lsu_ctrl_pkg.sv | 49 ++++
 rtl/ysyx_22040931_lsu_fmt.sv | 45 ++++
 rtl/ysyx_22040931_lsu_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040931_lsu_ctrl_pkg.sv
// Shared encodings for the LSU sequencer: decoder load/store ops, FSM states, access sizes.
package ysyx_22040931_lsu_ctrl_pkg;

  localparam logic [2:0] MEMROP_NONE = 3'b000;
  localparam logic [2:0] MEMROP_LB   = 3'b001;
  localparam logic [2:0] MEMROP_LH   = 3'b010;
  localparam logic [2:0] MEMROP_LW   = 3'b011;
  localparam logic [2:0] MEMROP_LD   = 3'b100;
  localparam logic [2:0] MEMROP_LBU  = 3'b101;
  localparam logic [2:0] MEMROP_LHU  = 3'b110;
  localparam logic [2:0] MEMROP_LWU  = 3'b111;

  localparam logic [2:0] MEMWOP_NONE = 3'b000;
  localparam logic [2:0] MEMWOP_SB   = 3'b001;
  localparam logic [2:0] MEMWOP_SH   = 3'b010;
  localparam logic [2:0] MEMWOP_SW   = 3'b011;
  localparam logic [2:0] MEMWOP_SD   = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  function automatic lsu_size_e rop_size(input logic [2:0] rop);
    case (rop)
      MEMROP_LH, MEMROP_LHU: rop_size = SZ_H;
      MEMROP_LW, MEMROP_LWU: rop_size = SZ_W;
      MEMROP_LD:             rop_size = SZ_D;
      default:               rop_size = SZ_B;
    endcase
  endfunction

  function automatic lsu_size_e wop_size(input logic [2:0] wop);
    case (wop)
      MEMWOP_SH: wop_size = SZ_H;
      MEMWOP_SW: wop_size = SZ_W;
      MEMWOP_SD: wop_size = SZ_D;
      default:   wop_size = SZ_B;
    endcase
  endfunction

  function automatic logic misaligned(input lsu_size_e sz, input logic [2:0] off);
    case (sz)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      SZ_D:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040931_lsu_fmt.sv
// Combinational byte-lane formatting: load extract/extend and store shift/mask.
module ysyx_22040931_lsu_fmt
  import ysyx_22040931_lsu_ctrl_pkg::*;
(
  input  logic [2:0]  ld_off,
  input  logic [2:0]  ld_op,
  input  logic [63:0] rdata,
  output logic [63:0] ld_val,
  input  logic [2:0]  st_off,
  input  logic [2:0]  st_op,
  input  logic [63:0] st_data,
  output logic [63:0] wdata,
  output logic [7:0]  wmask
);

  logic [63:0] lane;
  logic [7:0]  mask_base;

  always_comb begin
    lane = rdata >> {ld_off, 3'b000};
    case (ld_op)
      MEMROP_LB:  ld_val = {{56{lane[7]}}, lane[7:0]};
      MEMROP_LH:  ld_val = {{48{lane[15]}}, lane[15:0]};
      MEMROP_LW:  ld_val = {{32{lane[31]}}, lane[31:0]};
      MEMROP_LD:  ld_val = lane;
      MEMROP_LBU: ld_val = {56'd0, lane[7:0]};
      MEMROP_LHU: ld_val = {48'd0, lane[15:0]};
      MEMROP_LWU: ld_val = {32'd0, lane[31:0]};
      default:    ld_val = '0;
    endcase
  end

  always_comb begin
    case (st_op)
      MEMWOP_SB: mask_base = 8'h01;
      MEMWOP_SH: mask_base = 8'h03;
      MEMWOP_SW: mask_base = 8'h0F;
      MEMWOP_SD: mask_base = 8'hFF;
      default:   mask_base = 8'h00;
    endcase
    wdata = st_data << {st_off, 3'b000};
    wmask = mask_base << st_off;
  end

endmodule

// File: rtl/ysyx_22040931_lsu_ctrl.sv
// Multi-cycle load/store sequencer between decoder memory controls and a valid/ready bus.
// state | meaning: IDLE accept access | REQ request on bus | WAIT await response (drain after flush) | DONE one-cycle completion
module ysyx_22040931_lsu_ctrl
  import ysyx_22040931_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ena,
  input  logic              mem_wr,
  input  logic [2:0]        memrop,
  input  logic [2:0]        memwop,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] ld_data,
  output logic              err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_wr,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [7:0]        bus_req_wmask,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata
);

  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TMO_EN  = (TIMEOUT != 0);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic        drain_q;
  logic [2:0]  rop_q, off_q;
  logic        access, misal, tmo, kill;
  logic [63:0] ld_fmt, st_wdata;
  logic [7:0]  st_wmask;

  // Unknown store ops and "load with no op" are not accesses at all.
  assign access = mem_ena & ~flush &
                  (mem_wr ? (memwop != MEMWOP_NONE && memwop <= MEMWOP_SD)
                          : (memrop != MEMROP_NONE));
  assign misal  = misaligned(mem_wr ? wop_size(memwop) : rop_size(memrop), addr[2:0]);
  assign tmo    = TMO_EN && (cnt_q >= CNT_W'(TMO_LIM));
  assign kill   = drain_q | flush;

  ysyx_22040931_lsu_fmt u_fmt (
    .ld_off  (off_q),
    .ld_op   (rop_q),
    .rdata   (bus_rsp_rdata),
    .ld_val  (ld_fmt),
    .st_off  (addr[2:0]),
    .st_op   (memwop),
    .st_data (st_data),
    .wdata   (st_wdata),
    .wmask   (st_wmask)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = access;
        if (access) state_d = misal ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus_req_ready)  state_d = ST_WAIT;
        else if (flush)     state_d = ST_IDLE;
        else if (tmo)       state_d = ST_DONE;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (bus_rsp_valid || tmo) state_d = kill ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done          = (state_q == ST_DONE);
  assign bus_req_valid = (state_q == ST_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      rop_q         <= MEMROP_NONE;
      off_q         <= '0;
      err           <= 1'b0;
      ld_data       <= '0;
      bus_req_wr    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wmask <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (access) begin
          rop_q         <= mem_wr ? MEMROP_NONE : memrop;
          off_q         <= addr[2:0];
          cnt_q         <= '0;
          drain_q       <= 1'b0;
          err           <= misal;
          ld_data       <= '0;
          bus_req_wr    <= mem_wr;
          bus_req_addr  <= {addr[ADDR_W-1:3], 3'b000};
          bus_req_wdata <= mem_wr ? st_wdata : '0;
          bus_req_wmask <= mem_wr ? st_wmask : 8'h00;
        end
        ST_REQ, ST_WAIT: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          // A flush accepted together with ready still owes the bus a response.
          drain_q <= kill && (state_d == ST_WAIT);
          if (state_d == ST_DONE) begin
            if (state_q == ST_WAIT && bus_rsp_valid) begin
              err     <= 1'b0;
              ld_data <= bus_req_wr ? '0 : ld_fmt;
            end else begin
              err     <= 1'b1;
              ld_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
